lif_membrane_update: RTL and testbench
======================================

// Module: lif_membrane_update
// PURPOSE
// - Leaky integrate-and-fire membrane stage of the digital neuron. Holds the signed
//   Q12.9 membrane potential and drives it to the neighbouring shifter's input.
// - Consumes the shifter result, v_mem >>> b, as the leak term.
// - Each accepted synaptic sample updates the potential: v = sat(v - leak + syn).
// - On a threshold crossing: emits a one-cycle spike, resets v, and enters a
//   refractory window in which no input is accepted.
// PARAMETERS
// - W               21      data width, signed Q12.9 (1.0 = 512)
// - THRESH          5120    firing threshold (10.0); fire when v_next >= THRESH
// - V_RESET         0       potential loaded after a spike or on clear
// - REFRACT_CYCLES  4       cycles in_ready is held low after a spike; 0 = none
// - CNT_W           16      spike counter width
// PORTS
// - clk          in   1      clock; all state updates on the rising edge
// - rst_n        in   1      asynchronous active-low reset
// - clear        in   1      synchronous: v_mem<=V_RESET, state<=INTEGRATE, counters kept
// - in_valid     in   1      syn_in valid
// - in_ready     out  1      stage can accept; combinational, (state==INTEGRATE)
// - syn_in       in   W      signed weighted synaptic input, Q12.9
// - leak_in      in   W      signed leak term from the shifter (v_mem >>> b), Q12.9
// - v_mem        out  W      registered membrane potential; feeds the shifter input
// - spike        out  1      registered one-cycle fire pulse
// - spike_count  out  CNT_W  spikes since reset; saturates at all-ones
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - v_mem=0, spike=0, spike_count=0, refr_cnt=0, state=INTEGRATE.
//   - in_ready=1 once reset is released.
// - States:
//   - INTEGRATE: in_ready=1.
//   - REFRACT: in_ready=0; in_valid is ignored; v_mem is held.
// - Accept = in_valid & in_ready at a rising edge. Latency 1: the result is
//   visible on v_mem the cycle after accept.
// - Arithmetic:
//   - sum = sext(v_mem,W+2) - sext(leak_in,W+2) + sext(syn_in,W+2).
//   - Clamp sum to [-2^(W-1), 2^(W-1)-1], i.e. [-1048576, 1048575]. No wrap.
// - Fire: if the clamped sum >= THRESH on an accept, at the same edge:
//   - v_mem<=V_RESET, spike<=1, spike_count increments (saturating).
//   - If REFRACT_CYCLES>0: refr_cnt<=REFRACT_CYCLES and state<=REFRACT.
//   - If REFRACT_CYCLES=0: stay in INTEGRATE; a back-to-back accept next cycle is legal.
// - No fire: v_mem<=clamped sum, spike<=0.
// - No accept: v_mem held, spike<=0. leak_in has no effect without an accept.
// - REFRACT: refr_cnt decrements every cycle. When refr_cnt==1, next state is
//   INTEGRATE. in_ready is therefore low for exactly REFRACT_CYCLES cycles
//   following the spike edge.
// - Priority: rst_n > clear > fire/update.
//   - clear with an accept in the same cycle: the sample is dropped, no spike,
//     v_mem=V_RESET.
//   - clear during REFRACT: refractory ends immediately; in_ready=1 next cycle.
// - Reset mid-refractory or mid-pulse: all outputs return to reset values at once.
// TESTING
// - Reset: rst_n=0 then 1 -> v_mem=0, spike=0, spike_count=0, in_ready=1.
// - Integrate/fire: syn_in=2560, leak_in=0, accepted twice.
//   -> v_mem=2560 after the first; after the second, spike=1 for one cycle,
//      v_mem=0, spike_count=1, then in_ready=0 for exactly 4 cycles.
// - Leak: v_mem=4096, leak_in=512 (b=3), syn_in=0, accept -> v_mem=3584, spike=0.
// - Negative saturation: v_mem=-1048000, syn_in=-1000, leak_in=0, accept
//   -> v_mem=-1048576, no wrap to positive.
// - Refractory handshake: in_valid held 1 with syn_in=512 through the window
//   -> v_mem stays 0 until in_ready returns; first accept then gives v_mem=512.
// - Clear race: clear=1 with in_valid=1, syn_in=6000 -> v_mem=0, spike=0,
//   spike_count unchanged.

Source files
------------

// File: rtl/lif_membrane_update_if.sv
// Synaptic input handshake for the LIF membrane stage.
// master: in_valid/syn_in/leak_in out, in_ready in.
interface lif_membrane_update_if #(
  parameter int W = 21
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] syn_in;
  logic signed [W-1:0] leak_in;

  modport master (
    output in_valid,
    output syn_in,
    output leak_in,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  syn_in,
    input  leak_in,
    output in_ready
  );
endinterface

// File: rtl/lif_membrane_update.sv
// Leaky integrate-and-fire membrane: v = sat(v - leak + syn), spike + refractory.
// Ports: clk, rst_n, clear, in_if (slave handshake), v_mem, spike, spike_count.
module lif_membrane_update #(
  parameter int W              = 21,
  parameter int THRESH         = 5120,
  parameter int V_RESET        = 0,
  parameter int REFRACT_CYCLES = 4,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  lif_membrane_update_if.slave in_if,
  output logic signed [W-1:0]  v_mem,
  output logic                 spike,
  output logic [CNT_W-1:0]     spike_count
);

  localparam int RW = $clog2(REFRACT_CYCLES + 2);

  localparam logic signed [W+1:0] SMAX =
    {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SMIN =
    {3'b111, {(W-1){1'b0}}};

  localparam logic signed [W-1:0] TH = W'(THRESH);
  localparam logic signed [W-1:0] VR = W'(V_RESET);

  typedef enum logic {
    INTEGRATE = 1'b0,
    REFRACT   = 1'b1
  } state_t;

  state_t          state;
  logic [RW-1:0]   refr_cnt;

  logic signed [W+1:0] sum;
  logic signed [W-1:0] sat;
  logic                accept;
  logic                fire;
  logic                upd;
  logic                refr_on;

  assign in_if.in_ready = (state == INTEGRATE);

  assign accept = in_if.in_valid & in_if.in_ready;

  // Two guard bits cover the worst case of max - min + max.
  assign sum = {{2{v_mem[W-1]}}, v_mem}
             - {{2{in_if.leak_in[W-1]}}, in_if.leak_in}
             + {{2{in_if.syn_in[W-1]}}, in_if.syn_in};

  always_comb begin
    sat = sum[W-1:0];
    if (sum > SMAX) begin
      sat = {1'b0, {(W-1){1'b1}}};
    end else if (sum < SMIN) begin
      sat = {1'b1, {(W-1){1'b0}}};
    end
  end

  assign fire    = accept & (sat >= TH);
  assign upd     = accept & ~fire;
  assign refr_on = (state == REFRACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_mem       <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
      refr_cnt    <= '0;
      state       <= INTEGRATE;
    end else if (clear) begin
      v_mem    <= VR;
      spike    <= 1'b0;
      refr_cnt <= '0;
      state    <= INTEGRATE;
    end else begin
      spike <= 1'b0;
      unique case (1'b1)
        fire: begin
          v_mem <= VR;
          spike <= 1'b1;
          if (spike_count != '1) begin
            spike_count <= spike_count + CNT_W'(1);
          end
          if (REFRACT_CYCLES > 0) begin
            refr_cnt <= RW'(REFRACT_CYCLES);
            state    <= REFRACT;
          end
        end
        upd: begin
          v_mem <= sat;
        end
        refr_on: begin
          refr_cnt <= refr_cnt - RW'(1);
          if (refr_cnt == RW'(1)) begin
            state <= INTEGRATE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_membrane_update.sv
// Scoreboard bench for lif_membrane_update.
// Directed spec scenarios followed by randomized traffic.
module tb_lif_membrane_update;

  localparam int W      = 21;
  localparam int THRESH = 5120;
  localparam int REFR   = 4;
  localparam int VMAX   = 1048575;
  localparam int VMIN   = -1048576;
  localparam int CMAX   = 65535;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clear = 1'b0;
  logic signed [W-1:0] v_mem;
  logic                spike;
  logic [15:0]         spike_count;

  lif_membrane_update_if #(.W(W)) bus ();

  lif_membrane_update #(
    .W              (W),
    .THRESH         (THRESH),
    .V_RESET        (0),
    .REFRACT_CYCLES (REFR),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_if       (bus.slave),
    .v_mem       (v_mem),
    .spike       (spike),
    .spike_count (spike_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    v;
    bit    spk;
    int    cnt;
    bit    rdy;
    string tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference neuron: potential, spike count, refractory cycles left.
  int mv   = 0;
  int mcnt = 0;
  int mrem = 0;
  bit mspk = 0;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  task automatic cyc(input bit valid, input int syn, input int leak,
                     input bit clr, input bit rst, input string tag);
    exp_t e;
    int   s;
    bus.in_valid = valid;
    bus.syn_in   = W'(syn);
    bus.leak_in  = W'(leak);
    clear        = clr;
    rst_n        = rst;
    if (!rst) begin
      mv = 0; mcnt = 0; mrem = 0; mspk = 0;
    end else if (clr) begin
      mv = 0; mrem = 0; mspk = 0;
    end else if (valid && mrem == 0) begin
      s = mv - leak + syn;
      if (s > VMAX) s = VMAX;
      if (s < VMIN) s = VMIN;
      if (s >= THRESH) begin
        mv   = 0;
        mspk = 1;
        if (mcnt < CMAX) mcnt++;
        mrem = REFR;
      end else begin
        mv   = s;
        mspk = 0;
      end
    end else begin
      mspk = 0;
      if (mrem > 0) mrem--;
    end
    e.v   = mv;
    e.spk = mspk;
    e.cnt = mcnt;
    e.rdy = (mrem == 0);
    e.tag = tag;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".v_mem"}, int'(v_mem), e.v);
        chk({e.tag, ".spike"}, int'(spike), int'(e.spk));
        chk({e.tag, ".count"}, int'(spike_count), e.cnt);
        chk({e.tag, ".ready"}, int'(bus.in_ready), int'(e.rdy));
      end
    end
  end

  initial begin : stim
    int syn;
    int leak;
    bit v;
    bit c;
    bit r;
    cyc(0, 0, 0, 0, 0, "reset");
    cyc(0, 0, 0, 0, 0, "reset");
    cyc(0, 0, 0, 0, 1, "idle");
    cyc(1, 2560, 0, 0, 1, "int1");
    cyc(1, 2560, 0, 0, 1, "fire");
    repeat (REFR + 1) cyc(1, 512, 0, 0, 1, "refr_hold");
    cyc(0, 0, 0, 0, 1, "after_refr");
    cyc(0, 0, 0, 1, 1, "clr");
    cyc(1, 4096, 0, 0, 1, "load4096");
    cyc(0, 0, 777, 0, 1, "leak_noacc");
    cyc(1, 0, 512, 0, 1, "leak");
    cyc(0, 0, 0, 1, 1, "clr");
    cyc(1, -1048000, 0, 0, 1, "loadneg");
    cyc(1, -1000, 0, 0, 1, "negsat");
    cyc(1, -1048576, 1048575, 0, 1, "negsat2");
    cyc(0, 0, 0, 1, 1, "clr");
    cyc(1, 1048575, -1048576, 0, 1, "possat");
    cyc(0, 0, 0, 1, 1, "clr");
    cyc(1, 6000, 0, 1, 1, "clr_race");
    cyc(0, 0, 0, 0, 1, "post_race");
    cyc(1, 6000, 0, 0, 1, "fire2");
    cyc(1, 100, 0, 0, 1, "refr_in");
    cyc(0, 0, 0, 1, 1, "clr_refr");
    cyc(1, 100, 0, 0, 1, "acc_after_clr");
    cyc(1, 6000, 0, 0, 1, "fire3");
    cyc(0, 0, 0, 0, 0, "rst_mid");
    cyc(0, 0, 0, 0, 1, "post_rst");

    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0)
        syn = int'($urandom_range(0, 2097151)) - 1048576;
      else
        syn = int'($urandom_range(0, 6000)) - 2500;
      if ($urandom_range(0, 3) == 0)
        leak = int'($urandom_range(0, 4000)) - 2000;
      else
        leak = mv >>> $urandom_range(1, 7);
      cyc(v, syn, leak, c, r, "rand");
    end

    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
